// File: rtl/parking_request_initiator_pkg.sv
// Shared definitions for the parking registration initiator: state encoding and default widths.
package parking_request_initiator_pkg;

  localparam int TOKEN_W_DEF = 3;
  localparam int TIME_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_SEND_TOKEN = 3'd2,
    ST_SEND_TIME  = 3'd3,
    ST_GAP        = 3'd4,
    ST_DONE       = 3'd5,
    ST_FAIL       = 3'd6
  } state_t;

  function automatic logic is_send(input state_t s);
    return (s == ST_SEND_TOKEN) || (s == ST_SEND_TIME);
  endfunction

endpackage

// File: rtl/phase_timeout_counter.sv
// Per-phase cycle counter: cleared on phase entry, counts while enabled, flags the last allowed cycle.
module phase_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/parking_request_initiator.sv
// Terminal-side initiator: request, token phase, time phase, with per-phase timeout and full retries.
module parking_request_initiator
  import parking_request_initiator_pkg::*;
#(
  parameter int TOKEN_W   = TOKEN_W_DEF,
  parameter int TIME_W    = TIME_W_DEF,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [TOKEN_W-1:0] token_in,
  input  logic [TIME_W-1:0]  time_in,
  input  logic               P_register_enable,
  input  logic               Q_register_enable,
  output logic               request,
  output logic               confirm,
  output logic [TOKEN_W-1:0] user_token,
  output logic [TIME_W-1:0]  TimeData,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         dbg_state
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             state_q, state_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [TOKEN_W-1:0] tok_q;
  logic [TIME_W-1:0]  time_q;
  logic               capture, ack, expire, timer_clear;

  // Only the ack belonging to the current send phase counts; the other one is ignored.
  assign ack = ((state_q == ST_SEND_TOKEN) && P_register_enable) ||
               ((state_q == ST_SEND_TIME)  && Q_register_enable);

  assign timer_clear = !is_send(state_q) || (state_d != state_q);
  assign dbg_state   = state_q;

  phase_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (is_send(state_q)),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          retry_d = '0;
          capture = 1'b1;
        end
      end
      ST_REQ: state_d = ST_SEND_TOKEN;
      ST_SEND_TOKEN, ST_SEND_TIME: begin
        if (ack) begin
          state_d = (state_q == ST_SEND_TOKEN) ? ST_SEND_TIME : ST_DONE;
        end else if (expire) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_GAP;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_GAP:  state_d = ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      tok_q      <= '0;
      time_q     <= '0;
      request    <= 1'b0;
      confirm    <= 1'b0;
      user_token <= '0;
      TimeData   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (capture) begin
        tok_q  <= token_in;
        time_q <= time_in;
      end
      request    <= (state_d == ST_REQ) || is_send(state_d);
      confirm    <= is_send(state_d);
      user_token <= is_send(state_d) ? tok_q : '0;
      TimeData   <= (state_d == ST_SEND_TIME) ? time_q : '0;
      busy       <= (state_d != ST_IDLE);
      done       <= (state_d == ST_DONE);
      error      <= (state_d == ST_FAIL);
    end
  end

endmodule
